pc_block: RTL and testbench



---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_next_addr.sv | 35 +++
 rtl/pc_block.sv | 53 +++++
 tb/tb_pc_block.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and next-PC selection type for the program-counter block.
package pc_pkg;

  localparam int unsigned PC_WIDTH           = 32;
  localparam int unsigned INSTR_BYTES        = 4;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } next_pc_sel_t;

  function automatic next_pc_sel_t decode_sel(input logic control, input logic addcontrol);
    if (!control)   return SEL_SEQ;
    if (!addcontrol) return SEL_BRANCH;
    return SEL_JUMP;
  endfunction

endpackage

// File: rtl/pc_next_addr.sv
// Combinational next-PC generator: sequential adder, branch adder and select mux.
module pc_next_addr
  import pc_pkg::*;
#(
  parameter int unsigned STEP_BYTES = pc_pkg::INSTR_BYTES
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                control_i,
  input  logic                addcontrol_i,
  input  logic [PC_WIDTH-1:0] inc_i,
  output logic [PC_WIDTH-1:0] next_pc_o
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(STEP_BYTES);

  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] branch_pc;
  next_pc_sel_t        sel;

  // Word offset becomes a byte offset; the top two offset bits fall off.
  assign seq_pc    = pc_i + STEP;
  assign branch_pc = seq_pc + {inc_i[PC_WIDTH-3:0], 2'b00};
  assign sel       = decode_sel(control_i, addcontrol_i);

  // NOTE: assign a default before the case so no path leaves next_pc_o unassigned (no latch).
  always_comb begin
    next_pc_o = seq_pc;
    case (sel)
      SEL_BRANCH: next_pc_o = branch_pc;
      SEL_JUMP:   next_pc_o = inc_i;
      default:    next_pc_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_block.sv
// Program counter register with synchronous reset and stall enable.
// Define PC_ALIGN_EN to force every loaded value (including RESET_ADDR) to word alignment.
module pc_block #(
  parameter logic [31:0] RESET_ADDR  = pc_pkg::DEFAULT_RESET_ADDR,
  parameter int unsigned INSTR_BYTES = pc_pkg::INSTR_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        control,
  input  logic        addcontrol,
  input  logic [31:0] inc,
  output logic [31:0] addr
);

  import pc_pkg::PC_WIDTH;

  logic [PC_WIDTH-1:0] addr_q;
  logic [PC_WIDTH-1:0] addr_d;
  logic [PC_WIDTH-1:0] next_pc;

  pc_next_addr #(
    .STEP_BYTES (INSTR_BYTES)
  ) u_next (
    .pc_i         (addr_q),
    .control_i    (control),
    .addcontrol_i (addcontrol),
    .inc_i        (inc),
    .next_pc_o    (next_pc)
  );

  function automatic logic [PC_WIDTH-1:0] load_val(input logic [PC_WIDTH-1:0] v);
`ifdef PC_ALIGN_EN
    return {v[PC_WIDTH-1:2], 2'b00};
`else
    return v;
`endif
  endfunction

  always_comb begin
    addr_d = addr_q;
    if (reset)     addr_d = load_val(RESET_ADDR);
    else if (push) addr_d = load_val(next_pc);
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: tb/tb_pc_block.sv
// Self-checking bench for pc_block: directed steps, then random traffic against a reference model.
module tb_pc_block;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        control;
  logic        addcontrol;
  logic [31:0] inc;
  logic [31:0] addr;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] model_pc;

  pc_block dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .control    (control),
    .addcontrol (addcontrol),
    .inc        (inc),
    .addr       (addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] align(input logic [31:0] v);
`ifdef PC_ALIGN_EN
    return v & 32'hFFFF_FFFC;
`else
    return v;
`endif
  endfunction

  // Reference: PC value after one edge, derived from plain integer arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic rst, input logic en,
                                           input logic ctl, input logic abs_j, input logic [31:0] off);
    longint v;
    if (rst) return align(32'h0);
    if (!en) return pc;
    if (!ctl)       v = longint'(pc) + 4;
    else if (abs_j) v = longint'(off);
    else            v = longint'(pc) + 4 + longint'($signed(off)) * 4;
    return align(32'(v));
  endfunction

  task automatic check(input string tag, input logic [31:0] expected);
    n_cmp++;
    assert (addr === expected) else begin
      n_fail++;
      $error("FAIL %s: addr=%08h expected=%08h", tag, addr, expected);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic p, input logic c,
                      input logic a, input logic [31:0] i);
    reset = r; push = p; control = c; addcontrol = a; inc = i;
    @(posedge clk);
    #1;
    model_pc = ref_next(model_pc, r, p, c, a, i);
    check(tag, model_pc);
  endtask

  initial begin
    model_pc = 32'h0;
    reset = 1'b1; push = 1'b1; control = 1'b1; addcontrol = 1'b0; inc = 32'h0;

    // Reset for two edges, then sequential 4, 8.
    step("reset0", 1, 1, 1, 0, 32'h0);
    check("reset_val", 32'h0);
    step("reset1", 1, 0, 0, 0, 32'h0);
    step("seq4", 0, 1, 0, 0, 32'h0);
    check("seq4_abs", 32'h4);
    step("seq8", 0, 1, 0, 0, 32'h0);
    check("seq8_abs", 32'h8);

    // Stall with a jump request pending: held.
    for (int k = 0; k < 3; k++) step("stall", 0, 0, 1, 1, 32'h100);
    check("stall_abs", 32'h8);
    step("seq12", 0, 1, 0, 0, 32'h0);
    check("seq12_abs", 32'hC);

    // Branches, forward then backward.
    step("jump40", 0, 1, 1, 1, 32'h40);
    step("br_fwd", 0, 1, 1, 0, 32'h3);
    check("br_fwd_abs", 32'h50);
    step("br_back", 0, 1, 1, 0, 32'hFFFF_FFFC);
    check("br_back_abs", 32'h44);

    // Absolute jumps, including a misaligned target.
    step("jump400000", 0, 1, 1, 1, 32'h0040_0000);
    check("jump_abs", 32'h0040_0000);
    step("jump_unal", 0, 1, 1, 1, 32'h0000_1003);
`ifdef PC_ALIGN_EN
    check("jump_unal_abs", 32'h0000_1000);
`else
    check("jump_unal_abs", 32'h0000_1003);
`endif

    // Wrap at the top of the address space.
    step("jump_top", 0, 1, 1, 1, 32'hFFFF_FFFC);
    step("wrap", 0, 1, 0, 0, 32'h0);
    check("wrap_abs", 32'h0);

    // Reset beats a simultaneous jump.
    step("jump200", 0, 1, 1, 1, 32'h200);
    step("rst_prio", 1, 1, 1, 1, 32'h300);
    check("rst_prio_abs", 32'h0);

    // Random traffic, including occasional resets and stalls.
    for (int k = 0; k < 400; k++) begin
      step("random", ($urandom_range(31) == 0), ($urandom_range(3) != 0),
           1'($urandom), 1'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
